// File: rtl/count_pkg.sv
// count_pkg: shared constants and alarm state encoding for the count monitor slice.
//   MAX_COUNT_DEF : terminal value of the upstream 0..99 seconds counter
//   BCD_W         : width of one BCD digit
//   alarm_state_t : one-shot alarm FSM states (2-bit code exported for debug)
package count_pkg;

    localparam int MAX_COUNT_DEF = 99;
    localparam int BCD_W         = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        DONE    = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/bin2bcd_99.sv
// bin2bcd_99: combinational 8-bit binary to two BCD digits with saturation.
//   bin  : binary value
//   tens : BCD tens digit (9 when bin > MAX_COUNT)
//   ones : BCD ones digit (9 when bin > MAX_COUNT)
//   oor  : bin exceeds MAX_COUNT
module bin2bcd_99
    import count_pkg::*;
#(
    parameter int MAX_COUNT = MAX_COUNT_DEF
) (
    input  logic [7:0]       bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             oor
);

    // Out-of-range values display as 99 so the display never shows a non-BCD digit.
    always_comb begin
        oor  = bin > 8'(MAX_COUNT);
        tens = oor ? BCD_W'(9) : BCD_W'(bin / 8'd10);
        ones = oor ? BCD_W'(9) : BCD_W'(bin % 8'd10);
    end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: watches the 0..99 up/down seconds counter in the clk_1Hz domain.
//   clk_1Hz     : 1 Hz clock shared with the upstream counter
//   reset       : asynchronous, active-high
//   count       : binary count from the upstream counter
//   updown      : counting direction, 1 = up, 0 = down
//   alarm_en    : arm alarm; low forces IDLE
//   alarm_value : binary match value
//   alarm_ack   : user acknowledge, level-sampled while ringing
//   tens/ones   : BCD of the registered count (one cycle behind count)
//   wrap        : one-cycle pulse when a wrap is captured
//   laps        : net wrap count, saturating at 0 and LAP_MAX
//   alarm       : high while the alarm FSM is RINGING
//   range_err   : sticky flag, a count above MAX_COUNT was captured
//   alarm_state : FSM state code for debug
module count_monitor
    import count_pkg::*;
#(
    parameter int MAX_COUNT = MAX_COUNT_DEF,
    parameter int HOLD_SECS = 10,
    parameter int LAP_MAX   = 255
) (
    input  logic             clk_1Hz,
    input  logic             reset,
    input  logic [7:0]       count,
    input  logic             updown,
    input  logic             alarm_en,
    input  logic [7:0]       alarm_value,
    input  logic             alarm_ack,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             wrap,
    output logic [7:0]       laps,
    output logic             alarm,
    output logic             range_err,
    output logic [1:0]       alarm_state
);

    localparam logic [7:0] MAX8      = 8'(MAX_COUNT);
    localparam logic [7:0] LAP8      = 8'(LAP_MAX);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_SECS - 1);

    logic [7:0]   cnt_q;
    logic [7:0]   hold_cnt;
    logic         valid;
    logic         err_q;
    logic         oor;
    logic         up_wrap;
    logic         dn_wrap;
    logic         match;
    alarm_state_t state;
    alarm_state_t state_nx;

    bin2bcd_99 #(.MAX_COUNT(MAX_COUNT)) u_bcd (
        .bin  (cnt_q),
        .tens (tens),
        .ones (ones),
        .oor  (oor)
    );

    // Wrap compares the held value with the incoming one; valid suppresses the
    // first edge after reset when cnt_q holds the reset value, not real history.
    assign up_wrap = valid &&  updown && cnt_q == MAX8  && count == 8'd0;
    assign dn_wrap = valid && !updown && cnt_q == 8'd0  && count == MAX8;

    // An out-of-range alarm_value can never match, even against an out-of-range count.
    assign match = count == alarm_value && alarm_value <= MAX8;

    // Raise range_err in the same cycle the display saturates, then hold it.
    assign range_err   = err_q | oor;
    assign alarm_state = state;

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            valid <= 1'b0;
            err_q <= 1'b0;
            wrap  <= 1'b0;
            laps  <= '0;
        end else begin
            cnt_q <= count;
            valid <= 1'b1;
            err_q <= err_q | oor;
            wrap  <= up_wrap | dn_wrap;
            if (up_wrap && laps != LAP8)
                laps <= laps + 8'd1;
            else if (dn_wrap && laps != 8'd0)
                laps <= laps - 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        if (!alarm_en)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = ARMED;
                ARMED:   state_nx = match ? RINGING : ARMED;
                RINGING: state_nx = (alarm_ack || hold_cnt == HOLD_LAST) ? DONE : RINGING;
                DONE:    state_nx = (count != alarm_value) ? ARMED : DONE;
                default: state_nx = IDLE;
            endcase
    end

    // alarm decodes the next state so it rises and falls on the same edge as RINGING.
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            alarm    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            alarm    <= state_nx == RINGING;
            hold_cnt <= (state == RINGING) ? hold_cnt + 8'd1 : 8'd0;
        end
    end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Downstream consumer of the 0-99 up/down seconds counter; same clk_1Hz domain.
- Registers the binary count and splits it into BCD tens/ones for the display stage.
- Detects wrap-around in both directions and keeps a saturating lap count.
- Runs a one-shot alarm state machine that fires when the count matches a programmed value.

Parameters:
MAX_COUNT, 99, terminal value of the upstream counter; wrap points are MAX_COUNT->0 (up) and 0->MAX_COUNT (down)
HOLD_SECS, 10, maximum alarm assertion length in clk_1Hz cycles (1..255)
LAP_MAX, 255, saturation value of laps (must fit 8 bits)

Ports:
clk_1Hz  in  1  1 Hz clock, shared with upstream counter
reset  in  1  asynchronous, active-high
count  in  8  binary count from upstream counter
updown  in  1  direction from upstream counter: 1 = up, 0 = down
alarm_en  in  1  arm alarm; 0 forces IDLE
alarm_value  in  8  binary match value (0..MAX_COUNT)
alarm_ack  in  1  user acknowledge, level-sampled
tens  out  4  BCD tens of registered count
ones  out  4  BCD ones of registered count
wrap  out  1  one-cycle pulse on detected wrap
laps  out  8  net wrap count, saturating
alarm  out  1  alarm active (level)
range_err  out  1  sticky: an input count > MAX_COUNT was seen
alarm_state  out  2  FSM state code, debug

Interface: reset reset, asynchronous, active-high; clock clk_1Hz.

Behaviour:
- Reset values: internal cnt_q = 0, valid = 0, tens = 0, ones = 0, wrap = 0, laps = 0, alarm = 0, range_err = 0, state = IDLE.
  - Reset mid-operation aborts any alarm immediately.
- Every posedge:
  - cnt_q <= count.
  - valid <= 1.
  - tens/ones are combinational BCD of cnt_q, so they trail count by one cycle.
- BCD conversion: values > MAX_COUNT give tens = 9, ones = 9 and set range_err.
  - range_err clears only on reset.
- wrap is registered and asserted for exactly one cycle in the cycle cnt_q takes the new value.
  - Up wrap: valid && updown && cnt_q == MAX_COUNT && count == 0.
  - Down wrap: valid && !updown && cnt_q == 0 && count == MAX_COUNT.
  - No wrap while valid = 0. This covers the first edge after reset release, when upstream may sit at 0 or 99.
  - A direction change coinciding with a boundary does not count as a wrap; the condition is evaluated with the current updown only.
- laps:
  - +1 on up wrap, saturating at LAP_MAX.
  - -1 on down wrap, saturating at 0.
- Alarm FSM (2-bit encoding), priority: reset > alarm_en = 0 > other transitions.
  - IDLE (00): alarm = 0; -> ARMED when alarm_en = 1.
  - ARMED (01): alarm = 0; -> RINGING when count == alarm_value, evaluated on the incoming value; hold_cnt <= 0. alarm_ack is ignored here.
  - RINGING (10): alarm = 1; hold_cnt increments each cycle.
    - -> DONE when alarm_ack = 1, or when hold_cnt == HOLD_SECS-1.
    - Total assertion is therefore at most HOLD_SECS cycles.
  - DONE (11): alarm = 0; -> ARMED once count != alarm_value. This prevents retriggering while the counter is paused or a match persists.
  - alarm_en = 0 in any state -> IDLE next edge, and alarm drops the same edge.
- alarm is a registered decode of state; it is high in the cycles state == RINGING.
- alarm_value > MAX_COUNT never matches. This is legal; no error is raised.

Decomposition:
- Package count_pkg:
  - MAX_COUNT default constant.
  - alarm state typedef/localparams IDLE = 0, ARMED = 1, RINGING = 2, DONE = 3.
  - BCD digit width constant (4).
- Sub-module bin2bcd_99:
  - Combinational 8-bit binary to two BCD digits, with saturation and an out-of-range flag.
  - Reused by later display blocks.
- Remaining logic stays in one module: capture regs, wrap detect, laps, FSM with 8-bit hold_cnt.

Test Plan:
- Reset release with count = 99, updown = 0, then count 98: no wrap pulse; tens/ones = 9/9, then 9/8; laps = 0.
- Up sequence 97, 98, 99, 0, 1 with updown = 1: wrap high exactly one cycle, when tens/ones = 0/0; laps = 1. Repeat 256 wraps: laps saturates at 255.
- Down sequence 1, 0, 99, 98 with updown = 0 and laps = 2: one wrap pulse; laps = 1. Then down wraps from 0: laps stays at 0.
- alarm_en = 1, alarm_value = 5, count passes 5 with no ack:
  - alarm high exactly 10 cycles, then DONE.
  - Hold count at 5: no retrigger.
  - Count moves to 6: state = ARMED.
- Alarm ringing, alarm_ack on the 3rd ringing cycle: alarm low the next edge. alarm_en dropped during RINGING: state = IDLE and alarm = 0 the next edge. Assert reset mid-ring: all outputs return to reset values immediately.
- count = 120 for one cycle: tens/ones = 9/9; range_err = 1 and stays 1 after count returns to 10.
